// File: rtl/round_key_sequencer_pkg.sv
// Shared definitions for the AES round-key sequencer and the key expansion:
// key-size codes, round counts and FSM state encodings.
package round_key_sequencer_pkg;

  localparam logic [3:0] NK_AES128 = 4'd3;
  localparam logic [3:0] NK_AES256 = 4'd7;
  localparam int         NR_AES128 = 10;
  localparam int         NR_AES256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_KEY = 2'd1,
    ST_STREAM   = 2'd2,
    ST_DONE     = 2'd3
  } rks_state_t;

  // True only for the two supported key-size codes.
  function automatic logic nk_is_valid(input logic [3:0] nk);
    return (nk == NK_AES128) || (nk == NK_AES256);
  endfunction

  // Number of rounds for a key-size code; 0 for an unsupported code.
  function automatic logic [3:0] nk_to_nr(input logic [3:0] nk);
    logic [3:0] nr;
    nr = 4'd0;
    if (nk == NK_AES128) nr = 4'(NR_AES128);
    if (nk == NK_AES256) nr = 4'(NR_AES256);
    return nr;
  endfunction

endpackage

// File: rtl/aes_inv_mixcolumns.sv
// Combinational 128-bit InvMixColumns, one 32-bit column per generate lane.
// Only compiled when RK_INVMIX_EN is defined; otherwise no logic exists.
`ifdef RK_INVMIX_EN
module aes_inv_mixcolumns (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  // GF(2^8) multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns of one column; byte 0 is the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = col[31-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign o_state[127-32*gi -: 32] = inv_mix_col(i_state[127-32*gi -: 32]);
    end
  endgenerate

endmodule
`endif

// File: rtl/round_key_sequencer.sv
// Streams an AES key schedule out of the key-expansion memory, in encrypt
// (round 0..Nr) or decrypt (round Nr..0) order, over a valid/ready port.
// Optional feature macro RK_INVMIX_EN: decrypt keys for inner rounds are
// passed through InvMixColumns for the equivalent inverse cipher.
module round_key_sequencer
  import round_key_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dec,
  input  logic [3:0]        Nk,
  input  logic              key_ready,
  input  logic              abort,
  output logic [ADDR_W-1:0] Addr,
  input  logic [127:0]      ex_key,
  output logic [127:0]      rk_data,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [ADDR_W-1:0] rk_round,
  output logic              rk_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  rks_state_t        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_nr;
  logic              r_dec;
  logic [127:0]      r_rk_data;
  logic              r_rk_valid;
  logic [ADDR_W-1:0] r_rk_round;
  logic              r_done;
  logic              r_err;

  logic [ADDR_W-1:0] w_nr_sel;
  logic [ADDR_W-1:0] w_end_idx;
  logic [ADDR_W-1:0] w_idx_next;
  logic [127:0]      w_key;
  logic              w_hs;
  logic              w_last;

  assign w_nr_sel   = ADDR_W'(nk_to_nr(Nk));
  // Round index of the final key of the sequence; idx parks there.
  assign w_end_idx  = r_dec ? '0 : r_nr;
  assign w_idx_next = (r_idx == w_end_idx) ? r_idx
                    : (r_dec ? r_idx - ADDR_W'(1) : r_idx + ADDR_W'(1));
  assign w_hs       = r_rk_valid && rk_ready;
  assign w_last     = r_rk_valid && (r_rk_round == w_end_idx);

`ifdef RK_INVMIX_EN
  logic [127:0] w_inv_key;
  logic         w_inner_round;

  aes_inv_mixcolumns u_inv_mix (
    .i_state (ex_key),
    .o_state (w_inv_key)
  );

  // First and last keys of the decrypt schedule are used unmodified.
  assign w_inner_round = (r_idx != '0) && (r_idx != r_nr);
  assign w_key         = (r_dec && w_inner_round) ? w_inv_key : ex_key;
`else
  assign w_key = ex_key;
`endif

  // Sequencer FSM: request latch, key load/step, handshake and cancel paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_nr       <= '0;
      r_dec      <= 1'b0;
      r_rk_data  <= '0;
      r_rk_valid <= 1'b0;
      r_rk_round <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (nk_is_valid(Nk)) begin
              r_dec   <= dec;
              r_nr    <= w_nr_sel;
              r_idx   <= dec ? w_nr_sel : '0;
              r_state <= ST_WAIT_KEY;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_WAIT_KEY: begin
          if (abort) begin
            r_rk_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (key_ready) begin
            r_rk_data  <= w_key;
            r_rk_valid <= 1'b1;
            r_rk_round <= r_idx;
            r_idx      <= w_idx_next;
            r_state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (abort) begin
            r_rk_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (!key_ready) begin
            // Key memory went stale under us: cancel and flag it.
            r_rk_valid <= 1'b0;
            r_err      <= 1'b1;
            r_state    <= ST_IDLE;
          end else if (w_hs) begin
            if (w_last) begin
              r_rk_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_rk_data  <= w_key;
              r_rk_round <= r_idx;
              r_idx      <= w_idx_next;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Addr     = r_idx;
  assign rk_data  = r_rk_data;
  assign rk_valid = r_rk_valid;
  assign rk_round = r_rk_round;
  assign rk_last  = w_last;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Randomized self-checking bench for round_key_sequencer. A key memory is
// modelled as an array; expected keys come from a queue of round numbers
// built from the Nk/direction rules, not from the DUT's internals.
module tb_round_key_sequencer;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              dec;
  logic [3:0]        Nk;
  logic              key_ready;
  logic              abort;
  logic [ADDR_W-1:0] Addr;
  logic [127:0]      ex_key;
  logic [127:0]      rk_data;
  logic              rk_valid;
  logic              rk_ready;
  logic [ADDR_W-1:0] rk_round;
  logic              rk_last;
  logic              busy;
  logic              done;
  logic              err;

  logic [127:0] mem [16];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign ex_key = mem[Addr];

  round_key_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dec       (dec),
    .Nk        (Nk),
    .key_ready (key_ready),
    .abort     (abort),
    .Addr      (Addr),
    .ex_key    (ex_key),
    .rk_data   (rk_data),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // Reference InvMixColumns: matrix rows (14,11,13,9) rotated per output byte.
  function automatic logic [127:0] ref_invmix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], a[k]);
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] exp_key(input int r, input logic d, input int nr);
    logic [127:0] k;
    k = mem[r];
`ifdef RK_INVMIX_EN
    if (d && r > 0 && r < nr) k = ref_invmix(k);
`else
    if (d && nr < 0) k = ref_invmix(k);
`endif
    return k;
  endfunction

  // Full sequence: mode 0 = always ready, 1 = pattern 1,0,0,1,0, 2 = random.
  task automatic run_seq(input logic [3:0] nk, input logic d, input int mode, input int kr_delay);
    int exp_q[$];
    int nr, r, budget, pi, nidx;
    logic rdy, stalled;
    logic [127:0] held_data;
    logic [ADDR_W-1:0] held_addr;
    logic [4:0] pat;
    pat = 5'b01001;  // bit i = rk_ready in stall-pattern slot i
    nr = (nk == 4'd3) ? 10 : 14;
    for (int i = 0; i <= nr; i++) exp_q.push_back(d ? nr - i : i);
    start = 1'b1; Nk = nk; dec = d; key_ready = 1'b0; rk_ready = 1'b0;
    tick();
    start = 1'b0; Nk = 4'($urandom); dec = 1'($urandom);
    check("busy_after_start", {127'd0, busy}, 128'd1);
    check("first_addr", {124'd0, Addr}, 128'(d ? nr : 0));
    for (int i = 0; i < kr_delay; i++) begin
      check("valid_before_key", {127'd0, rk_valid}, 128'd0);
      tick();
    end
    key_ready = 1'b1;
    tick();
    check("valid_after_key", {127'd0, rk_valid}, 128'd1);
    budget = 400; pi = 0; stalled = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      budget--;
      if (!rk_valid) begin
        check("stream_valid", {127'd0, rk_valid}, 128'd1);
        break;
      end
      if (stalled) begin
        check("stall_data", rk_data, held_data);
        check("stall_addr", {124'd0, Addr}, {124'd0, held_addr});
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[pi % 5];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pi++;
      if (mode == 2 && $urandom_range(0, 7) == 0) begin
        start = 1'b1; Nk = ($urandom_range(0, 1) != 0) ? 4'd3 : 4'd7;
      end
      rk_ready = rdy;
      if (rdy) begin
        r = exp_q.pop_front();
        nidx = d ? ((r > 0) ? r - 1 : 0) : ((r < nr) ? r + 1 : nr);
        check("key_data", rk_data, exp_key(r, d, nr));
        check("key_round", {124'd0, rk_round}, 128'(r));
        check("key_last", {127'd0, rk_last}, {127'd0, exp_q.size() == 0});
        check("key_addr", {124'd0, Addr}, 128'(nidx));
        $display("key round %0d data %h last %0d", rk_round, rk_data, rk_last);
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_data = rk_data;
        held_addr = Addr;
      end
      tick();
      start = 1'b0;
    end
    if (budget == 0) check("stream_timeout", 128'd0, 128'd1);
    rk_ready = 1'b0;
    check("done_pulse", {127'd0, done}, 128'd1);
    check("valid_after_last", {127'd0, rk_valid}, 128'd0);
    tick();
    check("done_cleared", {127'd0, done}, 128'd0);
    check("idle_after_done", {127'd0, busy}, 128'd0);
  endtask

  // Start a sequence and get it to the point where a few keys were consumed.
  task automatic begin_stream(input logic d);
    start = 1'b1; Nk = 4'd3; dec = d; key_ready = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dec = 1'b0; Nk = 4'd0;
    key_ready = 1'b0; abort = 1'b0; rk_ready = 1'b0;
    fill_random();
    #23;
    check("rst_valid", {127'd0, rk_valid}, 128'd0);
    check("rst_data", rk_data, 128'd0);
    check("rst_round", {124'd0, rk_round}, 128'd0);
    check("rst_addr", {124'd0, Addr}, 128'd0);
    check("rst_flags", {124'd0, busy, done, err, rk_last}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // FIPS-197 AES-128 schedule, encrypt order, full throughput.
    mem[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    mem[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    mem[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    mem[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    mem[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    mem[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    mem[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    mem[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    mem[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    mem[9]  = 128'hac7766f319fadc2128d12941575c006e;
    mem[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    run_seq(4'd3, 1'b0, 0, 0);

    fill_random();
    run_seq(4'd7, 1'b1, 0, 0);
    run_seq(4'd3, 1'b0, 1, 0);
    run_seq(4'd7, 1'b0, 1, 5);
    for (int t = 0; t < 4; t++) begin
      fill_random();
      run_seq(($urandom_range(0, 1) != 0) ? 4'd3 : 4'd7, 1'($urandom), 2,
              $urandom_range(0, 3));
    end

`ifdef RK_INVMIX_EN
    for (int i = 0; i < 16; i++) mem[i] = {4{32'h8e4da1bc}};
    check("invmix_model", ref_invmix(mem[1]), {4{32'hdb135345}});
    run_seq(4'd3, 1'b1, 0, 0);
`endif

    // Invalid key size: error pulse only.
    start = 1'b1; Nk = 4'd5; dec = 1'b0;
    tick();
    start = 1'b0;
    check("bad_nk_err", {127'd0, err}, 128'd1);
    check("bad_nk_busy", {127'd0, busy}, 128'd0);
    check("bad_nk_valid", {127'd0, rk_valid}, 128'd0);
    tick();
    check("bad_nk_err_once", {127'd0, err}, 128'd0);
    $display("invalid nk: err pulse checked");

    // Abort mid-stream, coinciding with a handshake.
    begin_stream(1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", {127'd0, rk_valid}, 128'd0);
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_no_done", {127'd0, done}, 128'd0);
    tick();
    check("abort_no_done_later", {127'd0, done}, 128'd0);
    $display("abort: stream cancelled");

    // key_ready dropping while streaming.
    begin_stream(1'b1);
    key_ready = 1'b0;
    tick();
    check("krdrop_valid", {127'd0, rk_valid}, 128'd0);
    check("krdrop_err", {127'd0, err}, 128'd1);
    check("krdrop_busy", {127'd0, busy}, 128'd0);
    tick();
    check("krdrop_err_once", {127'd0, err}, 128'd0);
    check("krdrop_no_done", {127'd0, done}, 128'd0);
    $display("key_ready drop: err pulse checked");

    // Asynchronous reset mid-stream.
    begin_stream(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {127'd0, rk_valid}, 128'd0);
    check("arst_data", rk_data, 128'd0);
    check("arst_addr_round", {120'd0, Addr, rk_round}, 128'd0);
    check("arst_busy", {127'd0, busy}, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_no_done", {127'd0, done}, 128'd0);
    $display("async reset: outputs cleared");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
